// File: rtl/pri_queue_param_pkg.sv
// Shared types and helpers for the parametrised systolic priority queue.
// Optional sticky error flags are enabled with the PRI_QUEUE_ERR_EN macro.
package pri_queue_pkg;

    // Operation applied to every cell of the chain on a given edge.
    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        CLEAR   = 3'd1,
        LOAD    = 3'd2,
        SHIFT   = 3'd3,
        REPLACE = 3'd4
    } pq_op_e;

    localparam int PQ_WIDTH_DEFAULT = 8;
    localparam int PQ_DEPTH_DEFAULT = 6;

    // Occupancy counter width: must be able to represent 0..depth inclusive.
    function automatic int pq_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int PQ_CNT_W_DEFAULT = pq_cnt_w(PQ_DEPTH_DEFAULT);

endpackage

// File: rtl/pri_queue_param_if.sv
// Command/status bundle between a scheduler and the priority queue.
// The err status bits exist only when PRI_QUEUE_ERR_EN is defined.
interface pri_queue_param_if
    import pri_queue_pkg::*;
#(
    parameter int WIDTH = PQ_WIDTH_DEFAULT,
    parameter int DEPTH = PQ_DEPTH_DEFAULT
);
    localparam int CNT_W = pq_cnt_w(DEPTH);

    logic             clear;
    logic             loadIn;
    logic             shiftOut;
    logic [WIDTH-1:0] newVal;
    logic [WIDTH-1:0] top;
    logic             topValid;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
`ifdef PRI_QUEUE_ERR_EN
    logic [1:0]       err;

    modport master (
        output clear, loadIn, shiftOut, newVal,
        input  top, topValid, count, full, empty, err
    );

    modport slave (
        input  clear, loadIn, shiftOut, newVal,
        output top, topValid, count, full, empty, err
    );
`else
    modport master (
        output clear, loadIn, shiftOut, newVal,
        input  top, topValid, count, full, empty
    );

    modport slave (
        input  clear, loadIn, shiftOut, newVal,
        output top, topValid, count, full, empty
    );
`endif

endinterface

// File: rtl/pri_queue_cell.sv
// One slot of the systolic priority chain; decides its next entry from its
// own contents, its upper and lower neighbours, the incoming key and the op.
module pri_queue_cell
    import pri_queue_pkg::*;
#(
    parameter int WIDTH    = PQ_WIDTH_DEFAULT,
    parameter bit IS_FIRST = 1'b0
) (
    input  logic ck,
    input  logic r,
    input  pq_op_e op,
    input  logic [WIDTH-1:0] new_val,
    input  logic [WIDTH:0]   upper,
    input  logic [WIDTH:0]   lower,
    output logic [WIDTH:0]   entry
);

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] key;
    } pq_entry_t;

    pq_entry_t entry_reg;
    pq_entry_t entry_next;
    pq_entry_t upper_ent;
    pq_entry_t lower_ent;
    pq_entry_t own_view;
    pq_entry_t up_view;
    logic      ins_here;
    logic      take_up;

    assign upper_ent = pq_entry_t'(upper);
    assign lower_ent = pq_entry_t'(lower);

    // Replace shifts first, so the insert rule sees the chain as it would be
    // one slot higher: own contents come from below, upper contents are ours.
    always_comb begin
        own_view = entry_reg;
        up_view  = upper_ent;
        if (op == REPLACE) begin
            own_view = lower_ent;
            up_view  = entry_reg;
        end
    end

    always_comb begin
        ins_here = (!own_view.vld || (new_val > own_view.key)) &&
                   (IS_FIRST || (up_view.vld && (up_view.key >= new_val)));
        take_up  = !IS_FIRST && (!up_view.vld || (new_val > up_view.key));
    end

    always_comb begin
        entry_next = entry_reg;
        case (op)
            CLEAR:   entry_next = '0;
            SHIFT:   entry_next = lower_ent;
            LOAD, REPLACE: begin
                if (take_up) begin
                    entry_next = up_view;
                end else if (ins_here) begin
                    entry_next.vld = 1'b1;
                    entry_next.key = new_val;
                end else begin
                    entry_next = own_view;
                end
            end
            default: entry_next = entry_reg;
        endcase
    end

    always_ff @(posedge ck) begin
        if (!r) begin
            entry_reg <= '0;
        end else begin
            entry_reg <= entry_next;
        end
    end

    assign entry = entry_reg;

endmodule

// File: rtl/pri_queue_param.sv
// Parametrised descending priority queue built from a chain of DEPTH cells.
// Defining PRI_QUEUE_ERR_EN adds sticky drop/underflow flags on bus.err.
module pri_queue_param
    import pri_queue_pkg::*;
#(
    parameter int WIDTH = PQ_WIDTH_DEFAULT,
    parameter int DEPTH = PQ_DEPTH_DEFAULT
) (
    input  logic ck,
    input  logic r,
    pri_queue_param_if.slave bus
);

    localparam int PQ_CNT_W = pq_cnt_w(DEPTH);

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] key;
    } pq_entry_t;

    pq_entry_t           slot     [DEPTH];
    pq_entry_t           upper_in [DEPTH];
    pq_entry_t           lower_in [DEPTH];
    pq_op_e              op;
    logic [PQ_CNT_W-1:0] count_reg;
    logic [PQ_CNT_W-1:0] count_next;
    logic                is_full;
    logic                is_empty;

    assign is_full  = (count_reg == PQ_CNT_W'(DEPTH));
    assign is_empty = (count_reg == '0);

    // Illegal or meaningless requests collapse to HOLD so the cells never
    // see a load into a full chain or a shift of an empty one.
    always_comb begin
        op = HOLD;
        if (bus.clear) begin
            op = CLEAR;
        end else if (bus.loadIn && bus.shiftOut) begin
            op = is_empty ? LOAD : REPLACE;
        end else if (bus.loadIn) begin
            op = is_full ? HOLD : LOAD;
        end else if (bus.shiftOut) begin
            op = is_empty ? HOLD : SHIFT;
        end
    end

    always_comb begin
        count_next = count_reg;
        case (op)
            CLEAR:   count_next = '0;
            LOAD:    count_next = count_reg + PQ_CNT_W'(1);
            SHIFT:   count_next = count_reg - PQ_CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge ck) begin
        if (!r) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
            if (gi == 0) begin : g_first
                assign upper_in[gi] = '0;
            end else begin : g_mid_up
                assign upper_in[gi] = slot[gi-1];
            end

            // The last slot pulls in an invalid entry when the chain shifts up.
            if (gi == DEPTH - 1) begin : g_last
                assign lower_in[gi] = '0;
            end else begin : g_mid_dn
                assign lower_in[gi] = slot[gi+1];
            end

            pri_queue_cell #(
                .WIDTH    (WIDTH),
                .IS_FIRST (gi == 0)
            ) u_cell (
                .ck      (ck),
                .r       (r),
                .op      (op),
                .new_val (bus.newVal),
                .upper   (upper_in[gi]),
                .lower   (lower_in[gi]),
                .entry   (slot[gi])
            );
        end
    endgenerate

    assign bus.top      = slot[0].vld ? slot[0].key : '0;
    assign bus.topValid = slot[0].vld;
    assign bus.count    = count_reg;
    assign bus.full     = is_full;
    assign bus.empty    = is_empty;

`ifdef PRI_QUEUE_ERR_EN
    logic [1:0] err_reg;
    logic [1:0] err_next;

    // Only the single-command forms are errors; a replace is always legal.
    always_comb begin
        err_next = err_reg;
        if (bus.clear) begin
            err_next = '0;
        end else if (bus.loadIn && !bus.shiftOut && is_full) begin
            err_next[0] = 1'b1;
        end else if (bus.shiftOut && !bus.loadIn && is_empty) begin
            err_next[1] = 1'b1;
        end
    end

    always_ff @(posedge ck) begin
        if (!r) begin
            err_reg <= '0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign bus.err = err_reg;
`endif

endmodule

// File: tb/tb_pri_queue_param.sv
// Scoreboard bench for pri_queue_param (WIDTH=8, DEPTH=6); err bits are
// checked only when PRI_QUEUE_ERR_EN is defined.
module tb_pri_queue_param;

    logic ck;
    logic r;

    pri_queue_param_if #(.WIDTH(8), .DEPTH(6)) bus ();

    pri_queue_param #(.WIDTH(8), .DEPTH(6)) dut (
        .ck  (ck),
        .r   (r),
        .bus (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        int         cyc;
        logic [7:0] top;
        logic [2:0] cnt;
        logic [1:0] err;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc_count = 0;
    int   errors    = 0;
    int   checks    = 0;
    bit   stim_done = 1'b0;
    bit   mon_done  = 1'b0;
    int   idle_cnt  = 0;

    always @(posedge ck) cyc_count <= cyc_count + 1;

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: every expected result is due on a known cycle and is compared
    // on the falling edge after the rising edge that produced it.
    always @(negedge ck) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc == cyc_count) begin
            e = sb.pop_front();
            $display("txn %-12s top=%02h topValid=%0d count=%0d full=%0d empty=%0d",
                     e.name, bus.top, bus.topValid, bus.count, bus.full, bus.empty);
            chk(e.name, "top",      32'(bus.top),      32'(e.top));
            chk(e.name, "count",    32'(bus.count),    32'(e.cnt));
            chk(e.name, "topValid", 32'(bus.topValid), 32'(e.cnt != 0));
            chk(e.name, "full",     32'(bus.full),     32'(e.cnt == 3'd6));
            chk(e.name, "empty",    32'(bus.empty),    32'(e.cnt == 3'd0));
`ifdef PRI_QUEUE_ERR_EN
            chk(e.name, "err",      32'(bus.err),      32'(e.err));
`endif
        end
        if (stim_done && !mon_done) begin
            if (sb.size() == 0) begin
                mon_done = 1'b1;
            end else begin
                idle_cnt++;
                if (idle_cnt > 20) begin
                    errors++;
                    checks++;
                    $display("FAIL drain: got %0d pending expected 0", sb.size());
                    sb.delete();
                    mon_done = 1'b1;
                end
            end
        end
    end

    // Drive one cycle of stimulus and queue the result expected after the edge.
    task automatic apply(input bit rv, input bit clr, input bit ld, input bit sh,
                         input logic [7:0] v, input logic [7:0] et,
                         input logic [2:0] ec, input logic [1:0] ee,
                         input string nm);
        exp_t e;
        r            = rv;
        bus.clear    = clr;
        bus.loadIn   = ld;
        bus.shiftOut = sh;
        bus.newVal   = v;
        e.cyc  = cyc_count + 1;
        e.top  = et;
        e.cnt  = ec;
        e.err  = ee;
        e.name = nm;
        sb.push_back(e);
        @(negedge ck);
    endtask

    initial begin
        logic [7:0] keys [5];
        r            = 1'b0;
        bus.clear    = 1'b0;
        bus.loadIn   = 1'b0;
        bus.shiftOut = 1'b0;
        bus.newVal   = 8'h00;
        @(negedge ck);

        // Reset held for two edges while a load is requested
        apply(0, 0, 1, 0, 8'h55, 8'h00, 3'd0, 2'b00, "reset0");
        apply(0, 0, 1, 0, 8'h55, 8'h00, 3'd0, 2'b00, "reset1");

        // Sorted insert with a duplicate key
        keys = '{8'h10, 8'h40, 8'h20, 8'h40, 8'h05};
        apply(1, 0, 1, 0, keys[0], 8'h10, 3'd1, 2'b00, "load10");
        apply(1, 0, 1, 0, keys[1], 8'h40, 3'd2, 2'b00, "load40");
        apply(1, 0, 1, 0, keys[2], 8'h40, 3'd3, 2'b00, "load20");
        apply(1, 0, 1, 0, keys[3], 8'h40, 3'd4, 2'b00, "load40b");
        apply(1, 0, 1, 0, keys[4], 8'h40, 3'd5, 2'b00, "load05");
        apply(1, 0, 0, 1, 8'h00, 8'h40, 3'd4, 2'b00, "shift1");
        apply(1, 0, 0, 1, 8'h00, 8'h20, 3'd3, 2'b00, "shift2");
        apply(1, 0, 0, 1, 8'h00, 8'h10, 3'd2, 2'b00, "shift3");
        apply(1, 0, 0, 1, 8'h00, 8'h05, 3'd1, 2'b00, "shift4");
        apply(1, 0, 0, 1, 8'h00, 8'h00, 3'd0, 2'b00, "shift5");

        // Fill to full, drop on overflow, replace on full, then flush
        for (int k = 1; k <= 6; k++) begin
            apply(1, 0, 1, 0, 8'(k), 8'(k), 3'(k), 2'b00, $sformatf("fill%0d", k));
        end
        apply(1, 0, 1, 0, 8'h99, 8'h06, 3'd6, 2'b01, "drop99");
        apply(1, 0, 1, 1, 8'h03, 8'h05, 3'd6, 2'b01, "repl_full");
        apply(1, 1, 0, 0, 8'h00, 8'h00, 3'd0, 2'b00, "clear_full");

        // Replace on a two-entry queue
        apply(1, 0, 1, 0, 8'h30, 8'h30, 3'd1, 2'b00, "load30");
        apply(1, 0, 1, 0, 8'h20, 8'h30, 3'd2, 2'b00, "load20b");
        apply(1, 0, 1, 1, 8'h25, 8'h25, 3'd2, 2'b00, "repl25");
        apply(1, 0, 0, 1, 8'h00, 8'h20, 3'd1, 2'b00, "pop25");
        apply(1, 0, 0, 1, 8'h00, 8'h00, 3'd0, 2'b00, "pop20");

        // Underflow, then clear overriding a simultaneous load
        apply(1, 0, 0, 1, 8'h00, 8'h00, 3'd0, 2'b10, "shift_empty");
        apply(1, 0, 1, 0, 8'h07, 8'h07, 3'd1, 2'b10, "load07");
        apply(1, 1, 1, 0, 8'h66, 8'h00, 3'd0, 2'b00, "clear_load");

        // Replace on empty acts as a plain load
        apply(1, 0, 1, 1, 8'h42, 8'h42, 3'd1, 2'b00, "repl_empty");
        apply(1, 0, 0, 1, 8'h00, 8'h00, 3'd0, 2'b00, "pop42");

        // Reset mid-operation overrides load and shift
        apply(1, 0, 1, 0, 8'h08, 8'h08, 3'd1, 2'b00, "load08");
        apply(1, 0, 1, 0, 8'h09, 8'h09, 3'd2, 2'b00, "load09");
        apply(1, 0, 1, 0, 8'h0a, 8'h0a, 3'd3, 2'b00, "load0a");
        apply(1, 0, 1, 0, 8'h0b, 8'h0b, 3'd4, 2'b00, "load0b");
        apply(0, 0, 1, 1, 8'h77, 8'h00, 3'd0, 2'b00, "reset_mid");
        apply(1, 0, 0, 0, 8'h00, 8'h00, 3'd0, 2'b00, "hold");

        bus.loadIn   = 1'b0;
        bus.shiftOut = 1'b0;
        stim_done    = 1'b1;
        for (int w = 0; w < 50 && !mon_done; w++) @(negedge ck);
        @(negedge ck);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pri_queue_param.md
Name: pri_queue_param

Overview:
- Parametrised successor to the single-bit, fixed-depth priority queue.
- Holds up to DEPTH keys of WIDTH bits, sorted descending, in a systolic register chain.
- Largest key is always presented at `top`.
- Adds valid tracking, occupancy, full/empty flags and a single-cycle replace (load and shift together).
- Sits in the scheduler/sort datapath wherever the old queue was instantiated.

Parameters:
- WIDTH, 8: key width in bits (>=1).
- DEPTH, 6: number of entries (>=2).

Ports:
- ck  input  1  clock; all state changes on its rising edge.
- r  input  1  reset, synchronous, active-low; sampled on the rising edge of ck.
- clear  input  1  synchronous flush of all entries.
- loadIn  input  1  insert newVal this cycle.
- shiftOut  input  1  pop current top this cycle.
- newVal  input  WIDTH  key to insert.
- top  output  WIDTH  largest valid key; 0 when empty.
- topValid  output  1  queue non-empty.
- count  output  $clog2(DEPTH+1)  number of valid entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- **State.** Per slot i (0 = top): `key[i]` and `vld[i]`. Invariant: valid slots are contiguous from slot 0 and keys are non-increasing with i.
- **Reset.** r==0 at an edge: all `vld` = 0, all `key` = 0. Outputs then read top=0, topValid=0, count=0, full=0, empty=1.
- **Output timing.** All outputs are registered or derived from registers only. Every operation is visible the cycle after its edge (latency 1). No combinational path from any input to any output.
- **Operation priority** at each edge (r high):
  1. clear: empties the queue and clears all keys to 0; loadIn and shiftOut are ignored.
  2. loadIn and shiftOut together (replace): pop top and insert newVal in the same edge; count unchanged.
     - If empty: acts as load only; count becomes 1.
     - If full: legal; the pop frees the slot.
  3. loadIn only:
     - If not full: insert newVal at its sorted position; count+1.
     - If full: newVal is dropped and state is unchanged.
  4. shiftOut only:
     - If not empty: slots shift up by one and the last valid slot is invalidated; count-1.
     - If empty: no-op; count stays 0, with no underflow.
  5. Neither: hold.
- **Insert position.** newVal goes after all existing keys >= newVal. Equal keys therefore leave in FIFO order.
- **Insert rule per slot.** Each slot decides from its own contents, its upper neighbour and newVal; no global search.
  - A slot takes newVal when newVal > `key[i]` (or slot i is invalid) and (i==0 or `key[i-1]` >= newVal).
  - A slot takes its upper neighbour's entry when the upper neighbour also satisfies newVal > `key[i-1]`.
- **Replace rule.** The chain first shifts up, then the same insert rule is applied to the shifted contents, within one cycle.
- **Invalid slots.** Their key contents are don't-care internally, but `top` must read 0 when `topValid`=0.
- **Mid-operation reset.** r low overrides clear, loadIn and shiftOut at that edge.
- **Arithmetic.** Unsigned compare only; count never wraps.

Optional Feature:
- Macro: PRI_QUEUE_ERR_EN.
- When defined, adds output `err` (2 bits), sticky:
  - `err[0]`: loadIn-only while full (drop).
  - `err[1]`: shiftOut-only while empty.
  - Cleared by reset or clear.
  - Set one cycle after the offending edge.
- When undefined: no `err` port and no error logic; all other behaviour is identical.

Decomposition:
- Package `pri_queue_pkg`:
  - op-select enum `pq_op_e` (HOLD, CLEAR, LOAD, SHIFT, REPLACE);
  - `PQ_CNT_W` function/localparam derived from DEPTH;
  - typedef `pq_entry_t` struct {vld, key}, parameterised via WIDTH in the top module.
- One sub-module, `pri_queue_cell`:
  - holds a single entry;
  - inputs: upper-neighbour entry, lower-neighbour entry, newVal, op;
  - outputs: its own entry.
  - The top module instantiates DEPTH cells in a generate chain and keeps count and flags.

Test Plan (WIDTH=8, DEPTH=6):
- Reset: hold r=0 for 2 edges with loadIn=1, newVal=8'h55 -> top=0, topValid=0, count=0, empty=1.
- Sorted insert: load 0x10, 0x40, 0x20, 0x40, 0x05 -> top=0x40, count=5. Then 5 shifts return 0x40, 0x40, 0x20, 0x10, 0x05; finally empty=1.
- Full/drop: load 6 keys 1..6 -> full=1. Load 0x99 -> state unchanged, top=6, count=6, `err[0]`=1 if PRI_QUEUE_ERR_EN.
- Replace: queue {0x30, 0x20} plus loadIn and shiftOut with newVal=0x25 -> next cycle top=0x25, count=2. Replace on a full queue keeps count=6.
- Empty shift and clear:
  - shiftOut on empty -> count=0, `err[1]`=1 if the macro is defined.
  - Then load 0x7; clear together with loadIn=1 -> empty=1, top=0, err cleared.
- Reset mid-operation: queue at count=4, assert r=0 together with loadIn=1 and shiftOut=1 -> next cycle count=0, top=0.
